// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on operands and results.
// Optional iterative shift-add multiply on ALUop 011, enabled by defining MUL_EN.
// Without MUL_EN, 011 is treated as an undefined op.
module alu_mc #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [2:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

`ifdef MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;
`else
  typedef enum logic {S_IDLE = 1'b0, S_DONE = 1'b1} state_t;
`endif

  state_t         r_state;
  state_t         w_state_next;
  logic [W:0]     w_sum;
  logic [W:0]     w_diff;
  logic [W-1:0]   w_res;
  logic           w_ovf;
  logic           w_carry;
  logic           w_accept;
  logic [W-1:0]   r_result;
  logic           r_ovf;
  logic           r_carry;
  logic           r_zero;

`ifdef MUL_EN
  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] w_acc_next;
  logic [W-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic           w_mul_last;
  logic           w_is_mul;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_ready && in_valid;
  assign Result    = r_result;
  assign Overflow  = r_ovf;
  assign CarryOut  = r_carry;
  assign Zero      = r_zero;

  // Single-cycle ALU result and flags, computed from the live operands at acceptance
  always_comb begin
    w_sum   = {1'b0, A} + {1'b0, B};
    w_diff  = {1'b0, A} - {1'b0, B};
    w_res   = '0;
    w_ovf   = 1'b0;
    w_carry = 1'b0;
    case (ALUop)
      3'b000: w_res = A & B;
      3'b001: w_res = A | B;
      3'b010: begin
        w_res   = w_sum[W-1:0];
        w_carry = w_sum[W];
        w_ovf   = (A[W-1] == B[W-1]) && (w_sum[W-1] != A[W-1]);
      end
      3'b110: begin
        w_res   = w_diff[W-1:0];
        w_carry = w_diff[W];
        w_ovf   = (A[W-1] != B[W-1]) && (w_diff[W-1] != A[W-1]);
      end
      3'b111: w_res = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      default: ;
    endcase
  end

`ifdef MUL_EN
  // Multiplier step: conditionally add the shifted multiplicand
  always_comb begin
    w_is_mul   = (ALUop == 3'b011);
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_mul_last = (r_cnt == CW'(W - 1));
  end
`endif

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef MUL_EN
          if (w_is_mul) w_state_next = S_CALC;
          else          w_state_next = S_DONE;
`else
          w_state_next = S_DONE;
`endif
        end
      end
`ifdef MUL_EN
      S_CALC: if (w_mul_last) w_state_next = S_DONE;
`endif
      S_DONE: if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Result/flag registers and multiplier datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
`ifdef MUL_EN
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
`endif
    end else begin
`ifdef MUL_EN
      if (w_accept && w_is_mul) begin
        r_mcand  <= {{W{1'b0}}, A};
        r_mplier <= B;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (w_accept) begin
        r_result <= w_res;
        r_ovf    <= w_ovf;
        r_carry  <= w_carry;
        r_zero   <= (w_res == '0);
      end
      // Last iteration writes the result directly from the final accumulator sum
      if (r_state == S_CALC) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
        if (w_mul_last) begin
          r_result <= w_acc_next[W-1:0];
          r_ovf    <= |w_acc_next[2*W-1:W];
          r_carry  <= 1'b0;
          r_zero   <= (w_acc_next[W-1:0] == '0);
        end
      end
`else
      if (w_accept) begin
        r_result <= w_res;
        r_ovf    <= w_ovf;
        r_carry  <= w_carry;
        r_zero   <= (w_res == '0);
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (DATA_WIDTH=32): directed vector table,
// multi-cycle corner sequences, and randomized ops against a reference model.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   ALUop;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic         Overflow;
  logic         CarryOut;
  logic         Zero;

  int errors = 0;
  int checks = 0;

  alu_mc #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .ALUop    (ALUop),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result   (Result),
    .Overflow (Overflow),
    .CarryOut (CarryOut),
    .Zero     (Zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
    logic         cy;
    logic         z;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions (signed range checks, wide product)
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ov, output logic cy);
    longint sa, sb, s, smax, smin;
    logic [63:0] p;
    logic [63:0] u;
    sa = $signed(a);
    sb = $signed(b);
    smax = (64'sd1 <<< (W - 1)) - 1;
    smin = -(64'sd1 <<< (W - 1));
    r = '0; ov = 1'b0; cy = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        u  = 64'(a) + 64'(b);
        r  = u[W-1:0];
        cy = (u > 64'hFFFF_FFFF);
        s  = sa + sb;
        ov = (s > smax) || (s < smin);
      end
      3'b110: begin
        r  = a - b;
        cy = (a < b);
        s  = sa - sb;
        ov = (s > smax) || (s < smin);
      end
      3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
`ifdef MUL_EN
      3'b011: begin
        p  = 64'(a) * 64'(b);
        r  = p[W-1:0];
        ov = (p[63:W] != 0);
      end
`endif
      default: r = '0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
`ifdef MUL_EN
    if (op == 3'b011) return W + 1;
`endif
    return 1;
  endfunction

  // One full transaction: accept, scramble inputs, time latency, check, consume
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic eo, input logic ec, input logic ez,
                        input string nm);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk({nm, "_ready_timeout"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; A = a; B = b; ALUop = op;
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; ALUop = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk({nm, "_lat"},  64'(lat), 64'(exp_lat(op)));
    chk({nm, "_res"},  64'(Result), 64'(er));
    chk({nm, "_flags"}, {61'd0, Overflow, CarryOut, Zero}, {61'd0, eo, ec, ez});
    chk({nm, "_busy"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_idle"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  initial begin
    logic [W-1:0] r;
    logic         ov, cy, seen;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [2:0]   ops[8];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; ALUop = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(Result), 64'd0);
    chk("rst_flags", {61'd0, Overflow, CarryOut, Zero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors (expected values worked out by hand)
    vecs.push_back('{3'b010, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'b110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'b111, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'b001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{3'b101, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1});
`ifdef MUL_EN
    vecs.push_back('{3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{3'b011, 32'h0000_0003, 32'h0000_0007, 32'h0000_0015, 1'b0, 1'b0, 1'b0});
`else
    vecs.push_back('{3'b011, 32'h0000_0003, 32'h0000_0007, 32'h0000_0000, 1'b0, 1'b0, 1'b1});
`endif
    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, vecs[i].cy, vecs[i].z,
             $sformatf("vec%0d", i));

    // Backpressure: result held for 5 cycles, new requests refused
    @(negedge clk);
    in_valid = 1'b1; A = 32'd10; B = 32'd20; ALUop = 3'b010;
    @(posedge clk); #1;
    chk("bp_valid0", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; A = $urandom; B = $urandom; ALUop = 3'b000;
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", i),
          {out_valid, in_ready, Overflow, CarryOut, Zero, Result},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd30});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});

    // Reset while an operation is in flight: it must never be presented
    @(negedge clk);
    in_valid = 1'b1; A = 32'd3; B = 32'd7;
`ifdef MUL_EN
    ALUop = 3'b011;
`else
    ALUop = 3'b010;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef MUL_EN
    repeat (9) @(posedge clk);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < W + 5; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", 64'(seen), 64'd0);
    run_op(3'b010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, "post_rst_add");

    // Randomized ops against the reference model
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0:       begin a = $urandom; b = a; end
        1:       begin a = 32'h8000_0000 ^ 32'($urandom_range(0, 3)); b = $urandom; end
        2:       begin a = $urandom_range(0, 20); b = $urandom_range(0, 20); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      model(op, a, b, r, ov, cy);
      run_op(op, a, b, r, ov, cy, (r == '0), $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
